// File: rtl/key_event_encoder.sv
// Turns debounced key levels into queued press/release events with a valid/ready output.
// Optional macro KEY_EVT_RELEASE_EN: when defined, release events are queued as well as presses.
module key_event_encoder #(
    parameter int NUM_KEYS   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [3:0]          evt_data,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                fifo_full,
    output logic                overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] key_q, reported_q, reported_d;
    logic [3:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [3:0]          evt_data_q, evt_data_d;
    logic                evt_valid_q, evt_valid_d;
    logic                fifo_full_q, fifo_full_d;
    logic                overflow_q, overflow_d;

    logic [NUM_KEYS-1:0] pending_s, sel_mask_s;
    logic [2:0]          sel_idx_s;
    logic                sel_found_s, sel_level_s;
    logic                emit_s, silent_s, rd_en_s, wr_en_s;
    logic [3:0]          wr_data_s;

    // Scanner: isolate the lowest-index pending key and decide whether it is written or absorbed.
    always_comb begin
        pending_s   = key_q ^ reported_q;
        sel_mask_s  = pending_s & (~pending_s + {{(NUM_KEYS-1){1'b0}}, 1'b1});
        sel_found_s = |pending_s;
        sel_level_s = |(sel_mask_s & key_q);
        sel_idx_s   = 3'd0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            sel_idx_s = sel_idx_s | (sel_mask_s[k] ? 3'(k) : 3'd0);
        end
        rd_en_s = evt_valid_q & evt_ready;
`ifdef KEY_EVT_RELEASE_EN
        emit_s   = sel_found_s;
        silent_s = 1'b0;
`else
        emit_s   = sel_found_s & sel_level_s;
        silent_s = sel_found_s & ~sel_level_s;
`endif
        wr_en_s   = emit_s & ((count_q != DEPTH_C) | rd_en_s);
        wr_data_s = {sel_level_s, sel_idx_s};
    end

    // Next state; the head entry is precomputed so evt_data can leave straight from a flop.
    always_comb begin
        reported_d  = (wr_en_s | silent_s) ? (reported_q ^ sel_mask_s) : reported_q;
        overflow_d  = overflow_q | (emit_s & ~wr_en_s);
        wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en_s);
        rd_ptr_d    = rd_ptr_q + PTR_W'(rd_en_s);
        count_d     = count_q + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
        evt_valid_d = (count_d != {CNT_W{1'b0}});
        fifo_full_d = (count_d == DEPTH_C);
        if (count_d == {CNT_W{1'b0}}) begin
            evt_data_d = 4'h0;
        end else if (wr_en_s && (count_q == CNT_W'(rd_en_s))) begin
            evt_data_d = wr_data_s;
        end else begin
            evt_data_d = mem_q[rd_ptr_d];
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= {NUM_KEYS{1'b0}};
            reported_q  <= {NUM_KEYS{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            evt_data_q  <= 4'h0;
            evt_valid_q <= 1'b0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            key_q       <= key_in;
            reported_q  <= reported_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            evt_data_q  <= evt_data_d;
            evt_valid_q <= evt_valid_d;
            fifo_full_q <= fifo_full_d;
            overflow_q  <= overflow_d;
        end
    end

    // Event storage; stale contents are never visible because pointers and count reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    assign evt_data  = evt_data_q;
    assign evt_valid = evt_valid_q;
    assign fifo_full = fifo_full_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Converts the 8 debounced key levels from the key debouncer bank into a stream of discrete press/release events.
- Events are queued in a small FIFO and handed downstream through a valid/ready handshake.
- The note/tone control logic consumes events instead of polling raw key levels.
- Downstream sees exactly one event per reported level change; glitches shorter than the service time produce no event.

Parameters:
- NUM_KEYS, 8, number of key inputs; 2..8 supported; event index field is 3 bits.
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- key_in  input  NUM_KEYS  debounced key levels; 1 = pressed. Polarity is normalised upstream.
- evt_data  output  4  head event: bit3 = 1 press / 0 release; bits2:0 = key index.
- evt_valid  output  1  FIFO non-empty; evt_data is valid.
- evt_ready  input  1  consumer accepts the head event when evt_valid && evt_ready at a clk edge.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky; set when any change is pending while the FIFO is full; cleared only by rst.

Behaviour:
- Reset, synchronous on clk with rst = 1:
  - key_q = 0 and reported = 0 (all keys treated as released).
  - FIFO empty: evt_valid = 0, fifo_full = 0, evt_data = 0, overflow = 0.
  - rst has priority over all other activity. Events in flight are discarded.
- Keys held at reset release produce press events normally after reset.
- Input stage: key_q <= key_in every cycle. No further synchronisation; key_in is already synchronous to clk.
- Pending mask: pending = key_q ^ reported.
- Scanner, one event per cycle maximum:
  - Selects the lowest-index set bit i of pending.
  - If a write is allowed, writes {key_q[i], i} to the FIFO and sets reported[i] <= key_q[i] in the same edge.
  - A write is allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a read occurs in the same cycle.
- Glitch coalescing: a press followed by a release before service leaves pending[i] = 0, so no event is generated. Only net level changes are reported.
- Full FIFO:
  - No write; reported stays unchanged, so the change is held and emitted later with the then-current level. There is no loss of final state.
  - overflow is set that cycle.
- Latency: key_in change set up before edge E0 -> key_q updates at E0 -> event written at E1 -> evt_valid high after E1, provided the FIFO has space and no lower-index key is pending.
- Multiple simultaneous changes: emitted on consecutive cycles in ascending key index.
- FIFO behaviour:
  - Standard circular buffer with wrap-around pointers.
  - evt_data is driven from the head entry and stays stable while evt_valid && !evt_ready.
  - Read and write in the same cycle leave count unchanged, including when the FIFO is empty: a write into an empty FIFO is not readable until the next cycle.
- evt_valid and fifo_full are registered or derived from the registered count; there is no combinational path from evt_ready or key_in.

Optional Feature:
- Macro: KEY_EVT_RELEASE_EN.
- Defined: press and release events are both emitted, as described above.
- Undefined:
  - Release changes update reported[i] silently in the scan cycle with no FIFO write.
  - The silent update happens even when the FIFO is full.
  - bit3 of every event is 1.
  - Release changes never set overflow.

Test Plan:
- Reset release with key_in = 0, then key_in[3] 0->1 held -> exactly one event 0xB (press, idx 3); evt_valid high 2 edges after the change; after accept, evt_valid = 0.
- key_in = 8'b1000_0101 applied in one cycle, evt_ready = 1 -> events 0x8, 0xA, 0xF on consecutive cycles; then 8'h00 -> 0x0, 0x2, 0x7.
- evt_ready = 0, toggle keys until 8 events are queued -> fifo_full = 1. Next change sets overflow = 1 and no write occurs. Raise evt_ready -> the 8 queued events drain in order, then the held change appears with the current level.
- key_in[5] pulses high for 1 cycle while FIFO full, then FIFO drained -> no event for key 5 (coalesced); overflow stays 1 until rst.
- Assert rst with 4 events queued and key_in[1] = 1 -> evt_valid = 0 and overflow = 0 next edge; after rst deasserts -> single event 0x9.
- KEY_EVT_RELEASE_EN undefined: press then release key 2 with a full FIFO -> release consumes no slot and sets no overflow; only 0xA is ever seen.
